// File: rtl/adsr_envelope.sv
// ADSR envelope generator: steps a saturating level on each sample tick and
// scales a voice amplitude by the registered envelope.
module adsr_envelope #(
  parameter int unsigned ENV_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SAMPLE_TICK,
  input  logic             KEY,
  input  logic [ENV_W-1:0] ATTACK,
  input  logic [ENV_W-1:0] DECAY,
  input  logic [ENV_W-1:0] SUSTAIN,
  input  logic [ENV_W-1:0] RLEASE,
  input  logic [ENV_W-1:0] AMP_IN,
  output logic [ENV_W-1:0] ENV,
  output logic [2:0]       STATE,
  output logic             ACTIVE,
  output logic [ENV_W-1:0] AMP_OUT
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  localparam logic [ENV_W-1:0] EnvMax = '1;

  state_e           state_q;
  logic             key_q;
  logic [ENV_W-1:0] env_q;
  logic [ENV_W-1:0] amp_q;

  logic               rise, fall, gated;
  logic [ENV_W:0]     att_sum;
  logic [ENV_W:0]     dec_floor;
  logic [2*ENV_W-1:0] product;
  logic [ENV_W-1:0]   amp_d;

  assign rise  = KEY & ~key_q;
  assign fall  = ~KEY & key_q;
  assign gated = (state_q == StAttack) || (state_q == StDecay) || (state_q == StSustain);

  // One extra bit so the saturation tests cannot be fooled by wrap-around.
  assign att_sum   = {1'b0, env_q} + {1'b0, ATTACK};
  assign dec_floor = {1'b0, SUSTAIN} + {1'b0, DECAY};

  assign product = {{ENV_W{1'b0}}, AMP_IN} * {{ENV_W{1'b0}}, env_q};
  assign amp_d   = ENV_W'(product >> ENV_W);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      key_q   <= 1'b0;
      env_q   <= '0;
      amp_q   <= '0;
    end else begin
      key_q <= KEY;
      amp_q <= amp_d;
      if (rise) begin
        state_q <= StAttack;
      end else if (fall && gated) begin
        state_q <= StRelease;
      end else if (!fall && SAMPLE_TICK) begin
        // Gate edges swallow the tick of their cycle, hence the !fall guard.
        case (state_q)
          StIdle: env_q <= '0;
          StAttack: begin
            if ((ATTACK == '0) || (att_sum >= {1'b0, EnvMax})) begin
              env_q   <= EnvMax;
              state_q <= StDecay;
            end else begin
              env_q <= att_sum[ENV_W-1:0];
            end
          end
          StDecay: begin
            if ((DECAY == '0) || ({1'b0, env_q} <= dec_floor)) begin
              env_q   <= SUSTAIN;
              state_q <= StSustain;
            end else begin
              env_q <= env_q - DECAY;
            end
          end
          StSustain: env_q <= SUSTAIN;
          StRelease: begin
            if ((RLEASE == '0) || (env_q <= RLEASE)) begin
              env_q   <= '0;
              state_q <= StIdle;
            end else begin
              env_q <= env_q - RLEASE;
            end
          end
          default: begin
            env_q   <= '0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign ENV     = env_q;
  assign STATE   = state_q;
  assign ACTIVE  = (state_q != StIdle);
  assign AMP_OUT = amp_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed envelope scenarios plus a
// randomized run against an arithmetic reference model.
module tb_adsr_envelope;

  localparam int W   = 16;
  localparam int MAX = 65535;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         SAMPLE_TICK = 1'b0;
  logic         KEY = 1'b0;
  logic [W-1:0] ATTACK = '0, DECAY = '0, SUSTAIN = '0, RLEASE = '0, AMP_IN = '0;
  logic [W-1:0] ENV, AMP_OUT;
  logic [2:0]   STATE;
  logic         ACTIVE;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_env = 0, m_state = 0, m_amp = 0;
  bit m_kq = 0;

  adsr_envelope #(.ENV_W(W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SAMPLE_TICK(SAMPLE_TICK),
    .KEY        (KEY),
    .ATTACK     (ATTACK),
    .DECAY      (DECAY),
    .SUSTAIN    (SUSTAIN),
    .RLEASE     (RLEASE),
    .AMP_IN     (AMP_IN),
    .ENV        (ENV),
    .STATE      (STATE),
    .ACTIVE     (ACTIVE),
    .AMP_OUT    (AMP_OUT)
  );

  always #5 CLK = ~CLK;

  // State names: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  function automatic void model_update();
    bit rise, fall;
    if (RESET) begin
      m_env = 0; m_state = 0; m_kq = 0; m_amp = 0;
      return;
    end
    m_amp = int'((longint'(AMP_IN) * longint'(m_env)) / 65536);
    rise = KEY && !m_kq;
    fall = !KEY && m_kq;
    m_kq = KEY;
    if (rise) begin
      m_state = 1;
    end else if (fall) begin
      if (m_state >= 1 && m_state <= 3) m_state = 4;
    end else if (SAMPLE_TICK) begin
      case (m_state)
        0: m_env = 0;
        1: if (ATTACK == 0 || m_env + int'(ATTACK) >= MAX) begin
             m_env = MAX; m_state = 2;
           end else m_env = m_env + int'(ATTACK);
        2: if (DECAY == 0 || m_env <= int'(SUSTAIN) + int'(DECAY)) begin
             m_env = int'(SUSTAIN); m_state = 3;
           end else m_env = m_env - int'(DECAY);
        3: m_env = int'(SUSTAIN);
        default: if (RLEASE == 0 || m_env <= int'(RLEASE)) begin
             m_env = 0; m_state = 0;
           end else m_env = m_env - int'(RLEASE);
      endcase
    end
  endfunction

  // Apply one clock with the given tick value; model tracks every edge.
  task automatic cyc(input bit t);
    SAMPLE_TICK = t;
    @(posedge CLK);
    model_update();
    #1;
    SAMPLE_TICK = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    KEY   = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      n_vec++;
      if ({ENV, STATE, ACTIVE, AMP_OUT} !== {16'h0, 3'd0, 1'b0, 16'h0}) begin
        n_err++;
        $display("FAIL reset_idle tick%0d: env=%h st=%0d act=%b amp=%h, want all 0",
                 i, ENV, STATE, ACTIVE, AMP_OUT);
      end
    end
  endtask

  task automatic test_adsr();
    int e;
    do_reset();
    ATTACK = 16'h4000; DECAY = 16'h1000; SUSTAIN = 16'h8000; RLEASE = 16'h3000;
    KEY = 1'b1;
    cyc(1'b0);
    n_vec++;
    if ({ENV, STATE} !== {16'h0, 3'd1}) begin
      n_err++; $display("FAIL adsr_rise: env=%h st=%0d, want 0000/1", ENV, STATE);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      e = (i == 3) ? MAX : (i + 1) * 16'h4000;
      n_vec++;
      if ({ENV, STATE} !== {16'(e), (i == 3) ? 3'd2 : 3'd1}) begin
        n_err++; $display("FAIL adsr_attack%0d: env=%h st=%0d, want %h", i, ENV, STATE, e);
      end
      cyc(1'b0);
    end
    n_vec++;
    if ({ENV, STATE} !== {16'hFFFF, 3'd2}) begin
      n_err++; $display("FAIL adsr_hold: env=%h st=%0d, want ffff/2", ENV, STATE);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1);
      e = (i < 7) ? 16'hEFFF - i * 16'h1000 : 16'h8000;
      n_vec++;
      if ({ENV, STATE} !== {16'(e), (i < 7) ? 3'd2 : 3'd3}) begin
        n_err++; $display("FAIL adsr_decay%0d: env=%h st=%0d, want %h", i, ENV, STATE, e);
      end
    end
    SUSTAIN = 16'h7000;
    cyc(1'b1);
    n_vec++;
    if ({ENV, STATE} !== {16'h7000, 3'd3}) begin
      n_err++; $display("FAIL sustain_track: env=%h st=%0d, want 7000/3", ENV, STATE);
    end
    SUSTAIN = 16'h8000;
    cyc(1'b1);
    KEY = 1'b0;
    cyc(1'b0);
    n_vec++;
    if ({ENV, STATE} !== {16'h8000, 3'd4}) begin
      n_err++; $display("FAIL adsr_fall: env=%h st=%0d, want 8000/4", ENV, STATE);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      e = (i == 0) ? 16'h5000 : (i == 1) ? 16'h2000 : 0;
      n_vec++;
      if ({ENV, STATE, ACTIVE} !== {16'(e), (i == 2) ? 3'd0 : 3'd4, i != 2}) begin
        n_err++;
        $display("FAIL adsr_release%0d: env=%h st=%0d act=%b, want %h", i, ENV, STATE, ACTIVE, e);
      end
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    ATTACK = 16'h4000; DECAY = 16'h1000; SUSTAIN = 16'h8000; RLEASE = 16'h3000;
    KEY = 1'b1;
    cyc(1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1);
    KEY = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    KEY = 1'b1;
    cyc(1'b1);  // rising edge with a coincident tick
    n_vec++;
    if ({ENV, STATE} !== {16'h5000, 3'd1}) begin
      n_err++; $display("FAIL retrig_edge: env=%h st=%0d, want 5000/1", ENV, STATE);
    end
    cyc(1'b1);
    n_vec++;
    if ({ENV, STATE} !== {16'h9000, 3'd1}) begin
      n_err++; $display("FAIL retrig_step: env=%h st=%0d, want 9000/1", ENV, STATE);
    end
  endtask

  task automatic test_instant();
    do_reset();
    ATTACK = '0; DECAY = '0; RLEASE = '0; SUSTAIN = 16'h6000;
    KEY = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    n_vec++;
    if ({ENV, STATE} !== {16'hFFFF, 3'd2}) begin
      n_err++; $display("FAIL inst_attack: env=%h st=%0d, want ffff/2", ENV, STATE);
    end
    cyc(1'b1);
    n_vec++;
    if ({ENV, STATE} !== {16'h6000, 3'd3}) begin
      n_err++; $display("FAIL inst_decay: env=%h st=%0d, want 6000/3", ENV, STATE);
    end
    KEY = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    n_vec++;
    if ({ENV, STATE, ACTIVE} !== {16'h0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL inst_release: env=%h st=%0d act=%b, want 0/0/0", ENV, STATE, ACTIVE);
    end
  endtask

  task automatic test_amp_and_reset();
    do_reset();
    AMP_IN = 16'h8000; ATTACK = '0; DECAY = 16'h0100; SUSTAIN = 16'h1000;
    KEY = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    n_vec++;
    if ({ENV, AMP_OUT} !== {16'hFFFF, 16'h0}) begin
      n_err++; $display("FAIL amp_latency: env=%h amp=%h, want ffff/0000", ENV, AMP_OUT);
    end
    cyc(1'b0);
    n_vec++;
    if (AMP_OUT !== 16'h7FFF) begin
      n_err++; $display("FAIL amp_scale: amp=%h, want 7fff", AMP_OUT);
    end
    do_reset();
    ATTACK = 16'h1000;
    KEY = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    RESET = 1'b1;
    cyc(1'b1);  // reset beats tick and held key mid-attack
    n_vec++;
    if ({ENV, STATE, ACTIVE, AMP_OUT} !== {16'h0, 3'd0, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_mid_attack: env=%h st=%0d act=%b amp=%h, want all 0",
               ENV, STATE, ACTIVE, AMP_OUT);
    end
    RESET = 1'b0;
    cyc(1'b1);  // KEY still high: counts as a rising edge, tick swallowed
    n_vec++;
    if ({ENV, STATE} !== {16'h0, 3'd1}) begin
      n_err++; $display("FAIL key_held_reset: env=%h st=%0d, want 0000/1", ENV, STATE);
    end
    AMP_IN = '0;
  endtask

  function automatic logic [W-1:0] rand_rate();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 16'($urandom_range(1, 16'hFFFF));
      default: return 16'($urandom_range(1, 16'h2000));
    endcase
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        ATTACK = rand_rate(); DECAY = rand_rate(); RLEASE = rand_rate();
        SUSTAIN = 16'($urandom);
      end
      if ($urandom_range(0, 29) == 0) KEY = ~KEY;
      RESET  = ($urandom_range(0, 499) == 0);
      AMP_IN = 16'($urandom);
      cyc($urandom_range(0, 2) == 0);
      n_vec++;
      if ({ENV, STATE, ACTIVE, AMP_OUT} !==
          {16'(m_env), 3'(m_state), m_state != 0, 16'(m_amp)}) begin
        n_err++;
        $display("FAIL random cyc%0d: env=%h st=%0d act=%b amp=%h, want env=%h st=%0d amp=%h",
                 i, ENV, STATE, ACTIVE, AMP_OUT, m_env, m_state, m_amp);
      end
    end
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_adsr();
    test_retrigger();
    test_instant();
    test_amp_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
